text_codec_sequencer: RTL

Sequencer for the text compression loopback path. Accepts 8-bit ASCII bytes over a valid/ready handshake and presents each byte to `text_compressor`. After a fixed pipeline latency it checks the `text_expander` output against the held original, forwards the 7-bit compressed code downstream, and drives the `change` strobe of `error_counter`. It also keeps saturating byte, mismatch and reject statistics.

---
 rtl/text_codec_sequencer_pkg.sv | 19 +
 rtl/text_codec_sequencer_if.sv | 31 +++
 rtl/text_codec_sequencer_sat_counter.sv | 34 +++
 rtl/text_codec_sequencer.sv | 126 ++++++++++++
 4 files changed

// File: rtl/text_codec_sequencer_pkg.sv
// text_codec_pkg: types and widths shared by the text codec sequencer slice.
//   state_e   - sequencer FSM states
//   BYTE_W    - width of a source / expanded byte
//   SYMBOL_W  - width of a compressed symbol
//   ASCII_MSB - bit that marks a byte as not representable in 7 bits
package text_codec_pkg;

   localparam int unsigned BYTE_W    = 8;
   localparam int unsigned SYMBOL_W  = 7;
   localparam int unsigned ASCII_MSB = 7;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StCheck,
      StEmit
   } state_e;

endpackage

// File: rtl/text_codec_sequencer_if.sv
// text_codec_sequencer_if: byte source, codec loopback and symbol link signals.
//   in_byte/in_valid/in_ready        - source byte handshake
//   codec_byte/codec_code/
//   codec_expanded/err_change        - compressor / expander / error counter taps
//   out_code/out_valid/out_ready     - compressed symbol link handshake
// Modport slave is the sequencer's view; master is the surrounding environment.
interface text_codec_sequencer_if;
   import text_codec_pkg::*;

   logic [BYTE_W-1:0]   in_byte;
   logic                in_valid;
   logic                in_ready;
   logic [BYTE_W-1:0]   codec_byte;
   logic [SYMBOL_W-1:0] codec_code;
   logic [BYTE_W-1:0]   codec_expanded;
   logic                err_change;
   logic [SYMBOL_W-1:0] out_code;
   logic                out_valid;
   logic                out_ready;

   modport slave (
      input  in_byte, in_valid, codec_code, codec_expanded, out_ready,
      output in_ready, codec_byte, err_change, out_code, out_valid
   );

   modport master (
      output in_byte, in_valid, codec_code, codec_expanded, out_ready,
      input  in_ready, codec_byte, err_change, out_code, out_valid
   );

endinterface

// File: rtl/text_codec_sequencer_sat_counter.sv
// sat_counter: W-bit event counter that sticks at all-ones instead of wrapping.
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset, clears the count
//   inc   - count one event this cycle
//   count - registered count
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != '1)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/text_codec_sequencer.sv
// text_codec_sequencer: loopback sequencer for the text compressor/expander pair.
//   clk, reset     - clock and asynchronous active-high reset
//   enable         - permits acceptance of new bytes
//   bus            - source handshake, codec taps and symbol link (slave view)
//   byte_count     - bytes emitted on the link (saturating)
//   mismatch_count - round-trip mismatches (saturating)
//   reject_count   - non-ASCII bytes dropped (saturating)
//   busy           - a byte is in flight
// A byte is held on codec_byte, the codec pipeline is given LATENCY cycles, the round
// trip is compared in a single CHECK cycle and the compressed code is emitted.
module text_codec_sequencer
   import text_codec_pkg::*;
#(
   parameter int unsigned LATENCY = 2,
   parameter int unsigned COUNT_W = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   text_codec_sequencer_if.slave bus,
   output logic [COUNT_W-1:0]   byte_count,
   output logic [COUNT_W-1:0]   mismatch_count,
   output logic [COUNT_W-1:0]   reject_count,
   output logic                 busy
);

   localparam logic [3:0] WaitLoad = 4'(LATENCY - 1);

   state_e              state_q, state_d;
   logic [BYTE_W-1:0]   hold_q, hold_d;
   logic [SYMBOL_W-1:0] code_q, code_d;
   logic [3:0]          wait_q, wait_d;

   logic in_ready_w;
   logic accept, take, reject;
   logic byte_inc, mismatch_inc;

   assign in_ready_w = (state_q == StIdle) && enable;
   assign accept     = in_ready_w && bus.in_valid;
   assign reject     = accept && bus.in_byte[ASCII_MSB];
   assign take       = accept && !bus.in_byte[ASCII_MSB];

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (take) state_d = StWait;
         StWait:  if (wait_q == '0) state_d = StCheck;
         StCheck: state_d = StEmit;
         StEmit:  if (bus.out_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Datapath: hold register, wait counter, output code
   always_comb begin
      hold_d = hold_q;
      wait_d = wait_q;
      code_d = code_q;
      if (take) begin
         hold_d = bus.in_byte;
         wait_d = WaitLoad;
      end
      if ((state_q == StWait) && (wait_q != '0)) begin
         wait_d = wait_q - 1'b1;
      end
      if (state_q == StCheck) begin
         code_d = bus.codec_code;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_q <= '0;
         wait_q <= '0;
         code_q <= '0;
      end else begin
         hold_q <= hold_d;
         wait_q <= wait_d;
         code_q <= code_d;
      end
   end

   // Outputs
   always_comb begin
      bus.in_ready   = in_ready_w;
      bus.codec_byte = hold_q;
      bus.out_code   = code_q;
      bus.err_change = (state_q == StCheck);
      bus.out_valid  = (state_q == StEmit);
      busy           = (state_q != StIdle);
      mismatch_inc   = (state_q == StCheck) && (bus.codec_expanded != hold_q);
      byte_inc       = (state_q == StEmit) && bus.out_ready;
   end

   sat_counter #(.W(COUNT_W)) u_byte_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (byte_inc),
      .count (byte_count)
   );

   sat_counter #(.W(COUNT_W)) u_mismatch_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (mismatch_inc),
      .count (mismatch_count)
   );

   sat_counter #(.W(COUNT_W)) u_reject_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (reject),
      .count (reject_count)
   );

endmodule
